// File: rtl/sme_pkg.sv
// sme_pkg: shared state encoding, error codes and size defaults for the SME feeder
package sme_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEND_STR, SEND_PAT, WAIT_RES} state_t;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_NOSTR = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;
  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int WDOG_DEF    = 64;
endpackage

// File: rtl/sme_feeder_if.sv
// sme_feeder_if: upstream byte stream plus matcher-side strobes and error reporting
interface sme_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;
  logic       in_ready;
  logic       sme_out_valid;
  logic       isstring;
  logic       ispattern;
  logic [7:0] chardata;
  logic       err;
  logic [1:0] err_code;
  modport master (
    output in_valid, in_data, in_kind, in_last, sme_out_valid,
    input  in_ready, isstring, ispattern, chardata, err, err_code
  );
  modport slave (
    input  in_valid, in_data, in_kind, in_last, sme_out_valid,
    output in_ready, isstring, ispattern, chardata, err, err_code
  );
endinterface

// File: rtl/sme_char_buf.sv
// sme_char_buf: character buffer with one synchronous write port and one asynchronous read port
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = STR_MAX_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sme_feeder.sv
// sme_feeder: buffers string/pattern frames and replays them to the matcher, then waits for its result
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int WDOG    = WDOG_DEF
) (
  input logic        clk,
  input logic        rst_n,
  sme_feeder_if.slave bus
);
  localparam int CW = $clog2(STR_MAX + 1);
  localparam int AW = $clog2(STR_MAX);
  localparam int WW = $clog2(WDOG + 1);
  state_t          state_q, state_d;
  logic            kind_q, kind_d, drop_q, drop_d, ovf_q, ovf_d, str_loaded_q, str_loaded_d;
  logic            in_ready_q, in_ready_d, isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      chardata_q, chardata_d, rd_data;
  logic [CW-1:0]   cnt_q, cnt_d, idx_q, idx_d, base, lim;
  logic [WW-1:0]   wd_q, wd_d;
  logic [AW-1:0]   raddr;
  logic            acc, kind, drop, full, we, sending;
  sme_char_buf #(.DEPTH(STR_MAX)) u_buf (
    .clk  (clk),
    .we   (we),
    .waddr(AW'(base)),
    .wdata(bus.in_data),
    .raddr(raddr),
    .rdata(rd_data)
  );
  always_comb begin
    acc          = bus.in_valid && in_ready_q;
    sending      = state_q == SEND_STR || state_q == SEND_PAT;
    kind         = state_q == IDLE ? bus.in_kind : kind_q;
    drop         = state_q == IDLE ? bus.in_kind && !str_loaded_q : drop_q;
    base         = state_q == IDLE ? '0 : cnt_q;
    lim          = kind ? CW'(PAT_MAX) : CW'(STR_MAX);
    full         = base >= lim;
    we           = acc && !full && !drop;
    raddr        = sending ? AW'(idx_q + 1'b1) : '0;
    state_d      = state_q;
    kind_d       = kind;
    drop_d       = drop;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    str_loaded_d = str_loaded_q;
    isstring_d   = 1'b0;
    ispattern_d  = 1'b0;
    chardata_d   = '0;
    err_d        = 1'b0;
    err_code_d   = ERR_NONE;
    case (state_q)
      IDLE, LOAD: if (acc) begin
        cnt_d   = we ? base + 1'b1 : base;
        ovf_d   = state_q == LOAD && (ovf_q || full);
        state_d = LOAD;
        if (bus.in_last) begin
          idx_d       = '0;
          err_d       = drop || ovf_d;
          err_code_d  = drop ? ERR_NOSTR : ovf_d ? ERR_OVF : ERR_NONE;
          state_d     = drop ? IDLE : kind ? SEND_PAT : SEND_STR;
          isstring_d  = !drop && !kind;
          ispattern_d = !drop && kind;
          chardata_d  = drop ? '0 : state_q == IDLE ? bus.in_data : rd_data;
        end
      end
      SEND_STR, SEND_PAT: begin
        idx_d = idx_q + 1'b1;
        if (idx_d < cnt_q) begin
          isstring_d  = state_q == SEND_STR;
          ispattern_d = state_q == SEND_PAT;
          chardata_d  = rd_data;
        end else begin
          state_d      = state_q == SEND_STR ? IDLE : WAIT_RES;
          str_loaded_d = str_loaded_q || state_q == SEND_STR;
          wd_d         = '0;
        end
      end
      WAIT_RES: begin
        wd_d       = wd_q + 1'b1;
        err_d      = !bus.sme_out_valid && wd_q == WW'(WDOG - 1);
        err_code_d = err_d ? ERR_TMO : ERR_NONE;
        state_d    = bus.sme_out_valid || err_d ? IDLE : WAIT_RES;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE || state_d == LOAD;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      kind_q       <= 1'b0;
      drop_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wd_q         <= '0;
      str_loaded_q <= 1'b0;
      in_ready_q   <= 1'b0;
      isstring_q   <= 1'b0;
      ispattern_q  <= 1'b0;
      chardata_q   <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      str_loaded_q <= str_loaded_d;
      in_ready_q   <= in_ready_d;
      isstring_q   <= isstring_d;
      ispattern_q  <= ispattern_d;
      chardata_q   <= chardata_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.isstring  = isstring_q;
  assign bus.ispattern = ispattern_q;
  assign bus.chardata  = chardata_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed frames with a cycle-stamped scoreboard of expected matcher outputs
module tb_sme_feeder;
  localparam int WDOG = 64;
  typedef struct {
    int         cyc;
    logic       s;
    logic       p;
    logic [7:0] ch;
    logic       e;
    logic [1:0] code;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t x;
  sme_feeder_if bus();
  sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .WDOG(WDOG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, want, cyc);
    end
  endtask
  task automatic push(input int c, input logic s, input logic p, input logic [7:0] ch,
                      input logic e, input logic [1:0] code);
    exp_t t;
    t.cyc = c; t.s = s; t.p = p; t.ch = ch; t.e = e; t.code = code;
    q.push_back(t);
  endtask
  task automatic wait_cyc(input int c);
    int w = 0;
    while (cyc < c && w < 1000) begin
      step();
      w++;
    end
  endtask
  task automatic send_frame(input logic kind, input logic [7:0] d[$], output int e);
    int w = 0;
    while (!bus.in_ready && w < 200) begin
      step();
      w++;
    end
    chk("ready_before_frame", bus.in_ready, 1);
    foreach (d[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.in_kind  = kind;
      bus.in_last  = i == d.size() - 1;
      step();
    end
    e = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0 && cyc > q[0].cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_output: nothing seen, expected s=%0b p=%0b ch=%0h err=%0b code=%0d at cycle %0d (now %0d)",
               q[0].s, q[0].p, q[0].ch, q[0].e, q[0].code, q[0].cyc, cyc);
      void'(q.pop_front());
    end else if (bus.isstring || bus.ispattern || bus.err || bus.chardata != 0 || bus.err_code != 0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got s=%0b p=%0b ch=%0h err=%0b code=%0d at cycle %0d, expected none",
                 bus.isstring, bus.ispattern, bus.chardata, bus.err, bus.err_code, cyc);
      end else begin
        x = q.pop_front();
        if (x.cyc != cyc || bus.isstring !== x.s || bus.ispattern !== x.p || bus.chardata !== x.ch ||
            bus.err !== x.e || bus.err_code !== x.code) begin
          errors++;
          $display("FAIL output: got s=%0b p=%0b ch=%0h err=%0b code=%0d at cycle %0d, expected s=%0b p=%0b ch=%0h err=%0b code=%0d at cycle %0d",
                   bus.isstring, bus.ispattern, bus.chardata, bus.err, bus.err_code, cyc,
                   x.s, x.p, x.ch, x.e, x.code, x.cyc);
        end
      end
    end
  end
  initial begin
    int e;
    logic [7:0] d[$];
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_kind = 1'b0;
    bus.in_last = 1'b0;
    bus.sme_out_valid = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {bus.in_ready, bus.isstring, bus.ispattern, bus.chardata, bus.err, bus.err_code}, 0);
    rst_n = 1'b1;
    chk("ready_low_before_edge", bus.in_ready, 0);
    step();
    chk("ready_after_reset", bus.in_ready, 1);
    d = '{8'h41, 8'h42};
    send_frame(1'b1, d, e);
    push(e, 0, 0, 8'h00, 1, 2'b10);
    chk("ready_after_nostr", bus.in_ready, 1);
    bus.sme_out_valid = 1'b1;
    d = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    send_frame(1'b0, d, e);
    for (int k = 0; k < 5; k++) push(e + k, 1, 0, d[k], 0, 2'b00);
    chk("ready_during_string", bus.in_ready, 0);
    wait_cyc(e + 4);
    chk("ready_last_str_strobe", bus.in_ready, 0);
    step();
    chk("ready_after_string", bus.in_ready, 1);
    bus.sme_out_valid = 1'b0;
    d = '{8'h4C, 8'h4C};
    send_frame(1'b1, d, e);
    push(e, 0, 1, 8'h4C, 0, 2'b00);
    push(e + 1, 0, 1, 8'h4C, 0, 2'b00);
    wait_cyc(e + 3);
    chk("ready_waiting_result", bus.in_ready, 0);
    bus.sme_out_valid = 1'b1;
    step();
    bus.sme_out_valid = 1'b0;
    chk("ready_after_result", bus.in_ready, 1);
    d = {};
    for (int i = 0; i < 40; i++) d.push_back(8'(8'h10 + i));
    send_frame(1'b0, d, e);
    for (int k = 0; k < 32; k++) push(e + k, 1, 0, d[k], k == 0, k == 0 ? 2'b01 : 2'b00);
    wait_cyc(e + 32);
    chk("ready_after_long_string", bus.in_ready, 1);
    d = {};
    for (int i = 0; i < 10; i++) d.push_back(8'(8'h61 + i));
    send_frame(1'b1, d, e);
    bus.sme_out_valid = 1'b1;
    for (int k = 0; k < 8; k++) push(e + k, 0, 1, d[k], k == 0, k == 0 ? 2'b01 : 2'b00);
    wait_cyc(e + 8);
    chk("ready_wait_after_pat_ovf", bus.in_ready, 0);
    step();
    bus.sme_out_valid = 1'b0;
    chk("ready_after_pat_ovf_result", bus.in_ready, 1);
    d = '{8'h58};
    send_frame(1'b1, d, e);
    push(e, 0, 1, 8'h58, 0, 2'b00);
    push(e + 1 + WDOG, 0, 0, 8'h00, 1, 2'b11);
    wait_cyc(e + WDOG);
    chk("ready_before_timeout", bus.in_ready, 0);
    step();
    chk("ready_after_timeout", bus.in_ready, 1);
    d = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    send_frame(1'b0, d, e);
    for (int k = 0; k < 3; k++) push(e + k, 1, 0, d[k], 0, 2'b00);
    wait_cyc(e + 2);
    rst_n = 1'b0;
    step();
    chk("reset_mid_send_outputs", {bus.in_ready, bus.isstring, bus.ispattern, bus.chardata, bus.err, bus.err_code}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ready_after_mid_reset", bus.in_ready, 1);
    d = '{8'h51};
    send_frame(1'b1, d, e);
    push(e, 0, 0, 8'h00, 1, 2'b10);
    repeat (5) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
